// File: rtl/uart_rx_if.sv
// UART receive-side bundle: serial line in, recovered byte and status strobes out.
// Latency: none (wires only).
// Backpressure: none; done/frame_err are single-cycle strobes the consumer must take.
//
// Ports:
//   rxd       - serial line, idle high
//   data_out  - last correctly framed byte
//   done      - one-cycle pulse, data_out updated
//   frame_err - one-cycle pulse, stop bit sampled low
//   busy      - frame in progress
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data_out;
    logic       done;
    logic       frame_err;
    logic       busy;

    // Receiver side: consumes the line, produces the byte stream.
    modport master (
        input  rxd,
        output data_out,
        output done,
        output frame_err,
        output busy
    );

    // Line driver / byte consumer side.
    modport slave (
        output rxd,
        input  data_out,
        input  done,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: recovers bytes from an asynchronous serial line.
// Latency: done pulses the cycle after the mid-stop-bit sample (T0+HALF_BIT+9*CLKS_PER_BIT).
// Backpressure: none; done/frame_err are single-cycle strobes, data_out holds until the next good frame.
//
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - uart_rx_if.master (rxd in; data_out, done, frame_err, busy out)
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,            // even, >= 4
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [1:0]       sync;
    logic             rxd_s;

    state_t           state,     state_nxt;
    logic [CNT_W-1:0] cnt,       cnt_nxt;
    logic [2:0]       bit_idx,   bit_idx_nxt;
    logic [7:0]       shreg,     shreg_nxt;
    logic [7:0]       data_q,    data_nxt;
    logic             done_q,    done_nxt;
    logic             ferr_q,    ferr_nxt;
    logic             busy_q,    busy_nxt;

    // Two-flop synchroniser; resets to the idle (high) line level so a
    // line held low through reset is seen as a fresh start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], bus.rxd};
        end
    end

    assign rxd_s = sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            done_q  <= done_nxt;
            ferr_q  <= ferr_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_nxt    = data_q;
        done_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
        busy_nxt    = busy_q;

        unique case (state)
            IDLE: begin
                cnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (!rxd_s) begin
                    state_nxt = START;
                    busy_nxt  = 1'b1;
                end
            end

            // Confirm the start bit at its midpoint; a high here was a glitch.
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rxd_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end
            end

            // Counter is now phase-aligned to mid-bit; sample once per bit time.
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shreg_nxt[bit_idx] = rxd_s;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end

            // Leave at mid-stop-bit so a start edge right after the stop bit is caught.
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    if (rxd_s) begin
                        data_nxt = shreg;
                        done_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.done      = done_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver at 8 clk/bit, one at 4 clk/bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus8 ();
    uart_rx_if bus4 ();

    uart_rx #(.CLKS_PER_BIT(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    uart_rx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe/busy observation, sampled on the falling edge.
    int done_n8, ferr_n8, busy_n8, done_n4, ferr_n4, both_hi;
    int done_cyc8[$];
    int done_dat8[$];
    int ferr_cyc8[$];
    int done_cyc4[$];
    int done_dat4[$];
    int ferr_cyc4[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus8.done) begin
                done_n8++;
                done_cyc8.push_back(cyc);
                done_dat8.push_back(int'(bus8.data_out));
            end
            if (bus8.frame_err) begin
                ferr_n8++;
                ferr_cyc8.push_back(cyc);
            end
            if (bus8.busy) busy_n8++;
            if (bus4.done) begin
                done_n4++;
                done_cyc4.push_back(cyc);
                done_dat4.push_back(int'(bus4.data_out));
            end
            if (bus4.frame_err) begin
                ferr_n4++;
                ferr_cyc4.push_back(cyc);
            end
            if ((bus8.done && bus8.frame_err) || (bus4.done && bus4.frame_err)) both_hi++;
        end
    end

    task automatic clear_mon();
        done_n8 = 0; ferr_n8 = 0; busy_n8 = 0;
        done_n4 = 0; ferr_n4 = 0;
        done_cyc8.delete(); done_dat8.delete(); ferr_cyc8.delete();
        done_cyc4.delete(); done_dat4.delete(); ferr_cyc4.delete();
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_rxd(input bit sel, input logic b);
        if (sel) bus4.rxd = b;
        else     bus8.rxd = b;
    endtask

    // Drive one line level just after a rising edge and hold it for c cycles.
    task automatic drive_bit(input bit sel, input logic b, input int c);
        @(posedge clk);
        #1;
        set_rxd(sel, b);
        repeat (c - 1) @(posedge clk);
    endtask

    task automatic idle(input bit sel, input int n);
        drive_bit(sel, 1'b1, n);
    endtask

    // e = edge after which the start bit was driven; the receiver sees it at e+3.
    task automatic send_frame(input bit sel, input int c, input logic [7:0] d,
                              input logic stopv, output int e);
        @(posedge clk);
        #1;
        e = cyc;
        set_rxd(sel, 1'b0);
        repeat (c - 1) @(posedge clk);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i], c);
        drive_bit(sel, stopv, c);
    endtask

    initial begin
        int e, e2;
        logic [7:0] v;

        bus8.rxd = 1'b1;
        bus4.rxd = 1'b1;
        clear_mon();
        both_hi = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data8", bus8.data_out, 8'h00);
        check("rst_done8", bus8.done, 1'b0);
        check("rst_ferr8", bus8.frame_err, 1'b0);
        check("rst_busy8", bus8.busy, 1'b0);
        check("rst_data4", bus4.data_out, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(0, 5);

        // Good frame 0xA5: done at T0+4+72 = e+79, busy 76 cycles
        clear_mon();
        send_frame(0, 8, 8'hA5, 1'b1, e);
        idle(0, 20);
        check("a5_done_n", done_n8, 1);
        check("a5_done_cyc", qat(done_cyc8, 0) - e, 79);
        check("a5_data_q", qat(done_dat8, 0), 8'hA5);
        check("a5_data_out", bus8.data_out, 8'hA5);
        check("a5_ferr_n", ferr_n8, 0);
        check("a5_busy_cyc", busy_n8, 76);

        // Bad stop bit on 0x3C: one frame_err, data_out keeps 0xA5
        clear_mon();
        send_frame(0, 8, 8'h3C, 1'b0, e);
        idle(0, 30);
        check("bad_ferr_n", ferr_n8, 1);
        check("bad_ferr_cyc", qat(ferr_cyc8, 0) - e, 79);
        check("bad_done_n", done_n8, 0);
        check("bad_data_out", bus8.data_out, 8'hA5);

        // Back-to-back 0x00 then 0xFF, no idle gap
        clear_mon();
        send_frame(0, 8, 8'h00, 1'b1, e);
        send_frame(0, 8, 8'hFF, 1'b1, e2);
        idle(0, 20);
        check("b2b_done_n", done_n8, 2);
        check("b2b_first_cyc", qat(done_cyc8, 0) - e, 79);
        check("b2b_spacing", qat(done_cyc8, 1) - qat(done_cyc8, 0), 80);
        check("b2b_data0", qat(done_dat8, 0), 8'h00);
        check("b2b_data1", qat(done_dat8, 1), 8'hFF);

        // 3-cycle glitch: busy for 4 cycles only, no strobes
        clear_mon();
        drive_bit(0, 1'b0, 3);
        idle(0, 20);
        check("glitch_busy", busy_n8, 4);
        check("glitch_done", done_n8, 0);
        check("glitch_ferr", ferr_n8, 0);

        // Reset during data bit 4 of 0x5A
        clear_mon();
        v = 8'h5A;
        drive_bit(0, 1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(0, v[i], 8);
        @(posedge clk);
        #1;
        bus8.rxd = v[4];
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_data", bus8.data_out, 8'h00);
        check("mid_rst_busy", bus8.busy, 1'b0);
        check("mid_rst_done", bus8.done, 1'b0);
        check("mid_rst_ferr", bus8.frame_err, 1'b0);
        bus8.rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_busy2", bus8.busy, 1'b0);
        reset = 1'b0;
        idle(0, 90);
        check("abort_done", done_n8, 0);
        check("abort_ferr", ferr_n8, 0);
        clear_mon();
        send_frame(0, 8, 8'h81, 1'b1, e);
        idle(0, 20);
        check("post_rst_done", done_n8, 1);
        check("post_rst_data", bus8.data_out, 8'h81);

        // 4 clk/bit, frame 0xC3: done at T0+2+36 = e+41
        clear_mon();
        send_frame(1, 4, 8'hC3, 1'b1, e);
        idle(1, 20);
        check("c4_done_n", done_n4, 1);
        check("c4_done_cyc", qat(done_cyc4, 0) - e, 41);
        check("c4_data", qat(done_dat4, 0), 8'hC3);

        // Break: line low for 100 cycles -> frame_err at e+41, e+80; the frame
        // starting at e+81 sees the line rise mid-frame and completes as 0xF0.
        clear_mon();
        @(posedge clk);
        #1;
        e = cyc;
        bus4.rxd = 1'b0;
        repeat (99) @(posedge clk);
        idle(1, 60);
        check("brk_ferr_n", ferr_n4, 2);
        check("brk_ferr0", qat(ferr_cyc4, 0) - e, 41);
        check("brk_ferr1", qat(ferr_cyc4, 1) - e, 80);
        check("brk_done_n", done_n4, 1);
        check("brk_done_cyc", qat(done_cyc4, 0) - e, 119);
        check("brk_data", qat(done_dat4, 0), 8'hF0);

        check("never_both", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
